// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and types for the write-burst generator.
package axi_pkg;

    typedef logic [7:0] axi_awlen_t;
    typedef logic [1:0] axi_burst_t;
    typedef logic [8:0] burst_len_t;   // beat count of one burst, 1..256

    localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
    localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
    localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;

    localparam logic [2:0] AXI_SIZE_1B   = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B   = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B   = 3'd2;
    localparam logic [2:0] AXI_SIZE_8B   = 3'd3;
    localparam logic [2:0] AXI_SIZE_16B  = 3'd4;
    localparam logic [2:0] AXI_SIZE_32B  = 3'd5;
    localparam logic [2:0] AXI_SIZE_64B  = 3'd6;
    localparam logic [2:0] AXI_SIZE_128B = 3'd7;

    localparam int AXI_4KB_BYTES = 4096;

    typedef enum logic { AW_IDLE, AW_ISSUE } aw_state_e;

endpackage

// File: rtl/axi_len_fifo.sv
// Synchronous FIFO holding issued burst lengths until their W beats complete.
module axi_len_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is not reset; the empty flag keeps stale entries from ever being observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/axi_write_burst_gen.sv
// Splits a (start address, beat count) command into 4 KB-safe AXI INCR write bursts
// and frames the upstream beat stream with matching wlast.
module axi_write_burst_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_BURST_LEN  = 16,
    parameter int LEN_FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_WIDTH-1:0]     i_cmd_addr,
    input  logic [ADDR_WIDTH-2:0]     i_cmd_beats,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    output logic [ADDR_WIDTH-1:0]     o_awaddr,
    output logic [7:0]                o_awlen,
    output logic [2:0]                o_awsize,
    output logic [1:0]                o_awburst,
    output logic                      o_awvalid,
    input  logic                      i_awready,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    input  logic                      i_wvalid,
    output logic                      o_wready,
    output logic [DATA_WIDTH-1:0]     o_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_wstrb,
    output logic                      o_wlast,
    output logic                      o_wvalid,
    input  logic                      i_wready
);

    localparam int         BYTES   = DATA_WIDTH / 8;
    localparam int         BEATS_W = ADDR_WIDTH - 1;
    localparam int         PAGE_W  = (ADDR_WIDTH < 12) ? ADDR_WIDTH : 12;
    localparam logic [2:0] AW_SIZE = 3'($clog2(BYTES));

    aw_state_e           state;
    aw_state_e           state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BEATS_W-1:0]  remaining;
    burst_len_t          burst_len;
    logic [12:0]         beats_to_4k;
    logic                last_burst;
    logic                cmd_fire;
    logic                aw_fire;
    logic                w_fire;
    logic                fifo_full;
    logic                fifo_empty;
    burst_len_t          fifo_head;
    logic [7:0]          beat_cnt;

    assign beats_to_4k = (13'(AXI_4KB_BYTES) - 13'(addr[PAGE_W-1:0])) >> AW_SIZE;

    always_comb begin
        // NOTE: blocking assignments here so each line sees the running minimum from the line above.
        burst_len = burst_len_t'(MAX_BURST_LEN);
        if (32'(beats_to_4k) < 32'(burst_len)) burst_len = burst_len_t'(beats_to_4k);
        if (32'(remaining) < 32'(burst_len))   burst_len = burst_len_t'(remaining);
    end

    assign last_burst = (32'(remaining) == 32'(burst_len));
    assign cmd_fire   = i_cmd_valid && o_cmd_ready;
    assign aw_fire    = o_awvalid && i_awready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= AW_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        state_next  = state;
        o_cmd_ready = 1'b0;
        o_awvalid   = 1'b0;
        case (state)
            AW_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) state_next = AW_ISSUE;
            end
            AW_ISSUE: begin
                o_awvalid = !fifo_full;
                if (!fifo_full && i_awready && last_burst) state_next = AW_IDLE;
            end
            default: state_next = AW_IDLE;
        endcase
    end

    // Address and remaining count only move on a handshake, which keeps AW stable while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr      <= '0;
            remaining <= '0;
        end else if (cmd_fire) begin
            addr      <= i_cmd_addr;
            remaining <= i_cmd_beats;
        end else if (aw_fire) begin
            addr      <= addr + ADDR_WIDTH'(32'(burst_len) << AW_SIZE);
            remaining <= remaining - BEATS_W'(burst_len);
        end
    end

    assign o_awaddr  = (state == AW_ISSUE) ? addr : '0;
    assign o_awlen   = (state == AW_ISSUE) ? axi_awlen_t'(burst_len - 9'd1) : '0;
    assign o_awsize  = AW_SIZE;
    assign o_awburst = AXI_BURST_INCR;

    assign o_wvalid = i_wvalid && !fifo_empty;
    assign o_wready = i_wready && !fifo_empty;
    assign o_wdata  = i_wdata;
    assign o_wstrb  = '1;
    assign o_wlast  = !fifo_empty && (beat_cnt == axi_awlen_t'(fifo_head - 9'd1));
    assign w_fire   = o_wvalid && i_wready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        beat_cnt <= '0;
        else if (w_fire)     beat_cnt <= o_wlast ? 8'd0 : beat_cnt + 8'd1;
    end

    axi_len_fifo #(
        .WIDTH (9),
        .DEPTH (LEN_FIFO_DEPTH)
    ) u_len_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (aw_fire),
        .push_data (burst_len),
        .pop       (w_fire && o_wlast),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_cmd_beats_nonzero: assert property (@(posedge clk) disable iff (!reset_n)
        cmd_fire |-> (i_cmd_beats != '0));
    a_cmd_addr_aligned: assert property (@(posedge clk) disable iff (!reset_n)
        cmd_fire |-> ((64'(i_cmd_addr) & 64'(BYTES - 1)) == 64'd0));
    a_cmd_span_fits: assert property (@(posedge clk) disable iff (!reset_n)
        cmd_fire |-> ((64'(i_cmd_addr) + (64'(i_cmd_beats) << AW_SIZE)) <= (64'd1 << ADDR_WIDTH)));

endmodule

// File: tb/tb_axi_write_burst_gen.sv
// Bench for axi_write_burst_gen: a queue-level burst-planning model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_axi_write_burst_gen;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int BYTES = DW / 8;
    localparam int MAXB  = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] i_cmd_addr;
    logic [AW-2:0] i_cmd_beats;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [AW-1:0] o_awaddr;
    logic [7:0]    o_awlen;
    logic [2:0]    o_awsize;
    logic [1:0]    o_awburst;
    logic          o_awvalid;
    logic          i_awready;
    logic [DW-1:0] i_wdata;
    logic          i_wvalid;
    logic          o_wready;
    logic [DW-1:0] o_wdata;
    logic [DW/8-1:0] o_wstrb;
    logic          o_wlast;
    logic          o_wvalid;
    logic          i_wready;

    axi_write_burst_gen #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MAX_BURST_LEN  (MAXB),
        .LEN_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_cmd_addr  (i_cmd_addr),
        .i_cmd_beats (i_cmd_beats),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .o_awaddr    (o_awaddr),
        .o_awlen     (o_awlen),
        .o_awsize    (o_awsize),
        .o_awburst   (o_awburst),
        .o_awvalid   (o_awvalid),
        .i_awready   (i_awready),
        .i_wdata     (i_wdata),
        .i_wvalid    (i_wvalid),
        .o_wready    (o_wready),
        .o_wdata     (o_wdata),
        .o_wstrb     (o_wstrb),
        .o_wlast     (o_wlast),
        .o_wvalid    (o_wvalid),
        .i_wready    (i_wready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait budget expired at %0t", name, $time);
    endtask

    // ---------------- model: bursts still to issue, lengths awaiting W ----------------
    typedef struct {
        int addr;
        int len;
    } burst_rec_t;

    burst_rec_t exp_aw[$];
    int         wlenq[$];
    int         wbeat = 0;
    burst_rec_t aw_log[$];
    int         aw_wl_log[$];
    int         wlast_log[$];
    int         beat_total = 0;

    function automatic void plan(input int a, input int beats);
        int to4k;
        int len;
        while (beats > 0) begin
            to4k = (4096 - (a % 4096)) / BYTES;
            len  = beats;
            if (len > MAXB) len = MAXB;
            if (len > to4k) len = to4k;
            exp_aw.push_back('{addr: a, len: len});
            a     = (a + len * BYTES) % (1 << AW);
            beats = beats - len;
        end
    endfunction

    function automatic void clear_logs();
        aw_log.delete();
        aw_wl_log.delete();
        wlast_log.delete();
        beat_total = 0;
    endfunction

    function automatic int la(input int i);
        return (i < aw_log.size()) ? aw_log[i].addr : -1;
    endfunction
    function automatic int ll(input int i);
        return (i < aw_log.size()) ? aw_log[i].len : -1;
    endfunction
    function automatic int lw(input int i);
        return (i < wlast_log.size()) ? wlast_log[i] : -1;
    endfunction

    bit m_cmd_rdy;
    bit m_open;
    bit m_awv;
    bit m_last;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_aw.delete();
            wlenq.delete();
            wbeat = 0;
        end else begin
            m_cmd_rdy = (exp_aw.size() == 0);
            m_open    = (wlenq.size() > 0);
            m_awv     = !m_cmd_rdy && (wlenq.size() < DEPTH);
            m_last    = m_open && (wbeat == wlenq[0] - 1);
            check("cmd_ready", o_cmd_ready, m_cmd_rdy);
            check("awvalid",   o_awvalid, m_awv);
            check("wvalid",    o_wvalid, i_wvalid && m_open);
            check("wready",    o_wready, i_wready && m_open);
            check("wlast",     o_wlast, m_last);
            check("wstrb",     o_wstrb, 4'hF);
            check("wdata",     o_wdata, i_wdata);
            if (m_awv) begin
                check("awaddr",  o_awaddr, exp_aw[0].addr);
                check("awlen",   o_awlen, exp_aw[0].len - 1);
                check("awsize",  o_awsize, 3'd2);
                check("awburst", o_awburst, 2'b01);
            end
            if (m_open && i_wvalid && i_wready) begin
                beat_total++;
                if (m_last) begin
                    wlast_log.push_back(beat_total);
                    void'(wlenq.pop_front());
                    wbeat = 0;
                end else begin
                    wbeat++;
                end
            end
            if (m_awv && i_awready) begin
                aw_log.push_back(exp_aw[0]);
                aw_wl_log.push_back(wlast_log.size());
                wlenq.push_back(exp_aw[0].len);
                void'(exp_aw.pop_front());
            end
            if (m_cmd_rdy && i_cmd_valid) plan(int'(i_cmd_addr), int'(i_cmd_beats));
        end
    end

    // Upstream data changes every cycle so pass-through errors are visible.
    int cyc = 0;
    initial begin
        i_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            i_wdata = {8'hA5, 24'(cyc * 7)};
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (called in the posedge+1 phase) ----------------
    task automatic send_cmd(input int a, input int beats);
        int t;
        t = 0;
        i_cmd_addr  = AW'(a);
        i_cmd_beats = (AW-1)'(beats);
        i_cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!o_cmd_ready && t < 200);
        if (!o_cmd_ready) timeout("cmd_handshake");
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((exp_aw.size() != 0 || wlenq.size() != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) timeout(name);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awvalid"}, o_awvalid, 1'b0);
        check({tag, "_wvalid"},  o_wvalid, 1'b0);
        check({tag, "_wready"},  o_wready, 1'b0);
        check({tag, "_wlast"},   o_wlast, 1'b0);
        check({tag, "_awaddr"},  o_awaddr, 16'h0);
        check({tag, "_awlen"},   o_awlen, 8'h0);
        check({tag, "_cmd_rdy"}, o_cmd_ready, 1'b1);
    endtask

    initial begin
        int t;
        reset_n     = 1'b0;
        i_cmd_addr  = '0;
        i_cmd_beats = '0;
        i_cmd_valid = 1'b0;
        i_awready   = 1'b1;
        i_wvalid    = 1'b1;
        i_wready    = 1'b1;

        // Reset state with upstream valid and downstream ready held high.
        #12;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_release_cmd_rdy", o_cmd_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single 16-beat burst.
        clear_logs();
        send_cmd('h000, 16);
        wait_idle("t1_idle");
        check("t1_aw_n",   aw_log.size(), 1);
        check("t1_aw0_a",  la(0), 'h000);
        check("t1_aw0_l",  ll(0), 16);
        check("t1_wl_n",   wlast_log.size(), 1);
        check("t1_wl0",    lw(0), 16);

        // 40 beats split into 16/16/8.
        clear_logs();
        send_cmd('h000, 40);
        wait_idle("t2_idle");
        check("t2_aw_n",  aw_log.size(), 3);
        check("t2_aw0_a", la(0), 'h000);
        check("t2_aw0_l", ll(0), 16);
        check("t2_aw1_a", la(1), 'h040);
        check("t2_aw1_l", ll(1), 16);
        check("t2_aw2_a", la(2), 'h080);
        check("t2_aw2_l", ll(2), 8);
        check("t2_wl0",   lw(0), 16);
        check("t2_wl1",   lw(1), 32);
        check("t2_wl2",   lw(2), 40);

        // 4 KB boundary crossing.
        clear_logs();
        send_cmd('h0FF8, 4);
        wait_idle("t3_idle");
        check("t3_aw_n",  aw_log.size(), 2);
        check("t3_aw0_a", la(0), 'h0FF8);
        check("t3_aw0_l", ll(0), 2);
        check("t3_aw1_a", la(1), 'h1000);
        check("t3_aw1_l", ll(1), 2);
        check("t3_wl1",   lw(1), 4);

        // AW stalled for 5 cycles: valid and fields hold, no new command accepted.
        clear_logs();
        i_awready = 1'b0;
        send_cmd('h200, 8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_awvalid", o_awvalid, 1'b1);
            check("t4_awaddr",  o_awaddr, 16'h0200);
            check("t4_awlen",   o_awlen, 8'd7);
            check("t4_cmd_rdy", o_cmd_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        i_awready = 1'b1;
        wait_idle("t4_idle");
        check("t4_aw_n", aw_log.size(), 1);
        check("t4_wl0",  lw(0), 8);

        // W stalled: four lengths fill the FIFO, the fifth waits for the first wlast.
        clear_logs();
        i_wready = 1'b0;
        send_cmd('h400, 80);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t5_aw_n_stalled", aw_log.size(), 4);
        check("t5_awvalid_held", o_awvalid, 1'b0);
        @(posedge clk);
        #1;
        i_wready = 1'b1;
        wait_idle("t5_idle");
        check("t5_aw_n",       aw_log.size(), 5);
        check("t5_aw4_a",      la(4), 'h500);
        check("t5_aw4_after",  (aw_wl_log.size() > 4) ? aw_wl_log[4] : -1, 1);
        check("t5_wl0",        lw(0), 16);
        check("t5_wl4",        lw(4), 80);

        // Reset during the second burst's W beats with the third AW pending.
        clear_logs();
        send_cmd('h600, 40);
        repeat (2) @(posedge clk);
        #1;
        i_awready = 1'b0;
        t = 0;
        while (wlast_log.size() < 1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) timeout("t6_first_wlast");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6_pre_aw_n",    aw_log.size(), 2);
        check("t6_pre_awvalid", o_awvalid, 1'b1);
        check("t6_pre_wvalid",  o_wvalid, 1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        repeat (2) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        i_awready = 1'b1;
        @(negedge clk);
        check("t6_release_cmd_rdy", o_cmd_ready, 1'b1);
        check("t6_release_wvalid",  o_wvalid, 1'b0);
        @(posedge clk);
        #1;
        clear_logs();
        send_cmd('h800, 16);
        wait_idle("t6_idle");
        check("t6_aw_n",  aw_log.size(), 1);
        check("t6_aw0_a", la(0), 'h800);
        check("t6_aw0_l", ll(0), 16);
        check("t6_wl_n",  wlast_log.size(), 1);
        check("t6_wl0",   lw(0), 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
